accum_frame_feeder: RTL and testbench
=====================================

Name: accum_frame_feeder

Overview:
Upstream feeder for the 16-bit free-running accumulator (sync active-high clear, adds its input on every clock). Accepts samples over a valid/ready handshake and drives the accumulator input, forcing zero on idle cycles. Counts FRAME_LEN samples per frame, then captures the sum, clears the accumulator and presents the frame result downstream with an overflow flag and sample count.

Parameters:
WIDTH, 16, sample/accumulator width; must match the accumulator.
FRAME_LEN, 8, samples per frame (>=1).
CNT_W, $clog2(FRAME_LEN+1), width of the sample counter and res_count.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  sample valid.
in_data  in  WIDTH  unsigned sample.
in_ready  out  1  feeder can accept a sample this cycle.
flush  in  1  close the current frame early; level, sampled in RUN only.
acc_in  out  WIDTH  to accumulator input.
acc_clr  out  1  to accumulator reset (active-high, sync).
acc_out  in  WIDTH  from accumulator output.
res_valid  out  1  frame result valid.
res_ready  in  1  downstream accepts result.
res_data  out  WIDTH  captured frame sum (mod 2^WIDTH).
res_ovf  out  1  sum wrapped at least once during the frame.
res_count  out  CNT_W  samples in the frame (1..FRAME_LEN).

Behaviour:
- Reset (reset=0): state CLEAR, cnt=0, ovf_sticky=0, res_valid=0, res_data=0, res_ovf=0, res_count=0. Outputs: in_ready=0, acc_in=0, acc_clr=1 (accumulator is cleared by clocks while reset is held).
- States: CLEAR, RUN, DRAIN.
- CLEAR: acc_clr=1 and in_ready=0 for exactly one cycle, then RUN. Entered only from reset.
- RUN: in_ready=1. On accept (in_valid & in_ready): acc_in=in_data, cnt++. Otherwise acc_in=0.
- Overflow: on accept, carry = bit WIDTH of the (WIDTH+1)-bit sum acc_out+in_data. acc_out already includes every earlier accepted sample, because the accumulator has 1-cycle latency. Carry sets ovf_sticky.
- RUN->DRAIN: on the accept that makes cnt==FRAME_LEN, or when flush=1 and either cnt>0 or a sample is accepted in the same cycle. An accept in the same cycle as flush is counted and included in the frame. flush with cnt==0 and no accept is ignored.
- DRAIN: in_ready=0, acc_in=0, so acc_out is stable. Capture fires when (!res_valid | res_ready). On capture:
  - res_data<=acc_out, res_ovf<=ovf_sticky, res_count<=cnt, res_valid<=1.
  - acc_clr=1 this cycle; cnt<=0; ovf_sticky<=0; next state RUN.
  Without capture, stay in DRAIN with acc_clr=0 (stall; nothing lost).
- Result handshake: res_valid drops on res_valid & res_ready unless a capture happens in the same cycle, which keeps it at 1 with new data. res_* stay stable while res_valid & !res_ready.
- Latency: last sample accepted in cycle t. DRAIN in t+1, capture at the end of t+1 if the slot is free. res_valid=1 from t+2. in_ready=1 again from t+2. The minimum frame period is FRAME_LEN+1 cycles.
- acc_clr is combinational: (state==CLEAR) | capture. acc_in is combinational: accept ? in_data : 0.
- Width rules:
  - Sum wraps modulo 2^WIDTH; it never saturates.
  - res_count==FRAME_LEN for full frames, and less for flushed frames.
- Reset mid-frame: all state is discarded and the sequence restarts at CLEAR; any pending result is dropped.

Decomposition:
- Shared package: state enum (CLEAR, RUN, DRAIN), WIDTH default, and a result struct {data, ovf, count}.
- One natural sub-module, accum_result_slot: a one-deep valid/ready holding register for the result struct.
- The FSM, counter and overflow logic stay in the top level.

Test Plan:
- Reset then run: reset released -> acc_clr=1 for exactly 1 cycle, then in_ready=1; res_valid stays 0.
- Full frame: 8 back-to-back samples 1..8, res_ready=1 -> res_data=36, res_ovf=0, res_count=8; res_valid rises 2 cycles after the last accept; in_ready is low for exactly 1 cycle.
- Overflow: samples 0xFFFF, 0x0002, then six zeros -> res_data=0x0001, res_ovf=1; the next frame of zeros gives res_ovf=0.
- Flush: 3 samples of 0x0010, with flush asserted together with the 3rd -> res_data=0x0030, res_count=3. flush with cnt==0 produces no result.
- Backpressure: hold res_ready=0, complete frame A (sum 36), then complete frame B -> the FSM stalls in DRAIN with in_ready=0 and acc_clr=0, and res_data stays 36. Raising res_ready yields B's sum on the next cycle.
- Mid-frame reset: assert reset after 5 samples -> res_valid=0 and acc_clr=1 while reset is held. The next full frame of 1s gives res_data=8.

Source files
------------

// File: rtl/accum_frame_feeder_pkg.sv
// Shared types for the accumulator frame feeder.
// State encoding, default widths and the frame result record.
package accum_frame_feeder_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int FRAME_LEN_DEF = 8;
    localparam int CNT_W_DEF     = $clog2(FRAME_LEN_DEF + 1);

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] data;
        logic                 ovf;
        logic [CNT_W_DEF-1:0] count;
    } res_t;

endpackage

// File: rtl/accum_frame_feeder_slot.sv
// accum_result_slot: one-deep valid/ready holding register for a frame result.
// Ports: clk, reset (async active-low), load/d (capture), free, valid/ready/q (downstream).
module accum_result_slot
    import accum_frame_feeder_pkg::*;
#(
    parameter type T = res_t
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  T     d,
    output logic free,
    output logic valid,
    input  logic ready,
    output T     q
);

    logic valid_q;
    T     q_q;

    // The slot can take a new result when empty or when the current one
    // leaves this cycle.
    assign free  = !valid_q || ready;
    assign valid = valid_q;
    assign q     = q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else begin
            if (load && free) begin
                valid_q <= 1'b1;
                q_q     <= d;
            end else if (ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/accum_frame_feeder.sv
// accum_frame_feeder: feeds a free-running accumulator, frames FRAME_LEN samples.
// Ports: clk, reset (async active-low), in_* sample handshake, flush, acc_* to the
// accumulator, res_* frame result handshake (data, ovf, count).
module accum_frame_feeder
    import accum_frame_feeder_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] acc_in,
    output logic             acc_clr,
    input  logic [WIDTH-1:0] acc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic [CNT_W-1:0] res_count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ovf;
        logic [CNT_W-1:0] count;
    } frame_res_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             carry;
    logic             capture;
    logic             slot_free;
    frame_res_t       slot_d, slot_q;

    // acc_out holds every earlier accepted sample, so adding in_data
    // wraps exactly when acc_out exceeds the headroom ~in_data.
    assign carry = acc_out > ~in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        acc_in   = '0;
        acc_clr  = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                acc_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_in = in_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (carry) ovf_d = 1'b1;
                    if (cnt_q == LAST) state_d = DRAIN;
                end
                // A flush on an empty frame has nothing to report.
                if (flush && (cnt_q != '0 || in_valid)) state_d = DRAIN;
            end
            DRAIN: begin
                if (slot_free) begin
                    capture = 1'b1;
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                acc_clr = 1'b1;
                state_d = CLEAR;
            end
        endcase
    end

    assign slot_d = '{data: acc_out, ovf: ovf_q, count: cnt_q};

    accum_result_slot #(
        .T (frame_res_t)
    ) u_slot (
        .clk   (clk),
        .reset (reset),
        .load  (capture),
        .d     (slot_d),
        .free  (slot_free),
        .valid (res_valid),
        .ready (res_ready),
        .q     (slot_q)
    );

    assign res_data  = slot_q.data;
    assign res_ovf   = slot_q.ovf;
    assign res_count = slot_q.count;

endmodule

// File: tb/tb_accum_frame_feeder.sv
// Bench for accum_frame_feeder with a behavioural accumulator attached.
// Expected frame results are queued at stimulus time and popped on transfer.
module tb_accum_frame_feeder;

    localparam int W  = 16;
    localparam int FL = 8;
    localparam int CW = $clog2(FL + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          flush;
    logic [W-1:0]  acc_in;
    logic          acc_clr;
    logic [W-1:0]  acc_out;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          res_ovf;
    logic [CW-1:0] res_count;

    typedef struct {
        logic [W-1:0]  data;
        logic          ovf;
        logic [CW-1:0] count;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    accum_frame_feeder #(
        .WIDTH     (W),
        .FRAME_LEN (FL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .acc_in    (acc_in),
        .acc_clr   (acc_clr),
        .acc_out   (acc_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_count (res_count)
    );

    // Free-running accumulator: sync active-high clear, adds every clock.
    always @(posedge clk) begin
        if (acc_clr) acc_out <= '0;
        else         acc_out <= acc_out + acc_in;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic f);
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        #1;
        check("send_in_ready", 32'(in_ready), 32'd1);
        check("send_acc_in", 32'(acc_in), 32'(d));
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic expect_res(input logic [W-1:0] d, input logic o,
                              input logic [CW-1:0] c);
        exp_t e;
        e.data  = d;
        e.ovf   = o;
        e.count = c;
        sb.push_back(e);
    endtask

    // Scoreboard side: a result leaves at the next edge when valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed data %0h expected none",
                       res_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_ovf", 32'(res_ovf), 32'(e.ovf));
                check("res_count", 32'(res_count), 32'(e.count));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        res_ready = 1'b1;

        // Reset state
        tick();
        check("rst_acc_clr", 32'(acc_clr), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_acc_in", 32'(acc_in), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        tick();

        // Release: one CLEAR cycle then RUN
        reset = 1'b1;
        #1;
        check("clr_acc_clr", 32'(acc_clr), 32'd1);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("run_acc_clr", 32'(acc_clr), 32'd0);
        check("run_in_ready", 32'(in_ready), 32'd1);
        check("run_acc_in_idle", 32'(acc_in), 32'd0);
        check("run_res_valid", 32'(res_valid), 32'd0);

        // Full frame 1..8
        expect_res(16'd36, 1'b0, CW'(8));
        for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
        check("full_drain_in_ready", 32'(in_ready), 32'd0);
        check("full_drain_acc_clr", 32'(acc_clr), 32'd1);
        check("full_drain_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("full_res_valid", 32'(res_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd1);
        check("full_res_data", 32'(res_data), 32'd36);
        tick();
        check("full_res_valid_drop", 32'(res_valid), 32'd0);

        // Overflow frame, then a clean frame of zeros
        expect_res(16'h0001, 1'b1, CW'(8));
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b0);
        for (int i = 0; i < 6; i++) send(16'h0000, 1'b0);
        tick();
        check("ovf_res_ovf", 32'(res_ovf), 32'd1);
        tick();
        expect_res(16'h0000, 1'b0, CW'(8));
        for (int i = 0; i < 8; i++) send(16'h0000, 1'b0);
        tick();
        check("zero_res_ovf", 32'(res_ovf), 32'd0);
        tick();

        // Flush with the third sample
        expect_res(16'h0030, 1'b0, CW'(3));
        send(16'h0010, 1'b0);
        send(16'h0010, 1'b0);
        send(16'h0010, 1'b1);
        check("flush_drain_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush_res_count", 32'(res_count), 32'd3);
        tick();

        // Flush on an empty frame is ignored
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("eflush_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        flush = 1'b0;
        tick();
        check("eflush_res_valid", 32'(res_valid), 32'd0);

        // Backpressure: frame A (36) held, frame B (10..17 = 108) stalls
        res_ready = 1'b0;
        expect_res(16'd36, 1'b0, CW'(8));
        for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
        tick();
        check("bp_a_valid", 32'(res_valid), 32'd1);
        expect_res(16'd108, 1'b0, CW'(8));
        for (int i = 10; i <= 17; i++) send(W'(i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_in_ready", 32'(in_ready), 32'd0);
            check("bp_stall_acc_clr", 32'(acc_clr), 32'd0);
            check("bp_stall_res_data", 32'(res_data), 32'd36);
            check("bp_stall_res_valid", 32'(res_valid), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_acc_clr", 32'(acc_clr), 32'd1);
        tick();
        check("bp_b_valid", 32'(res_valid), 32'd1);
        check("bp_b_data", 32'(res_data), 32'd108);
        check("bp_b_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_b_drop", 32'(res_valid), 32'd0);

        // Mid-frame reset after 5 samples
        for (int i = 0; i < 5; i++) send(16'h0001, 1'b0);
        reset = 1'b0;
        #1;
        check("mrst_res_valid", 32'(res_valid), 32'd0);
        check("mrst_acc_clr", 32'(acc_clr), 32'd1);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("mrst_hold_acc_clr", 32'(acc_clr), 32'd1);
        reset = 1'b1;
        #1;
        check("mrst_clr_acc_clr", 32'(acc_clr), 32'd1);
        tick();
        check("mrst_run_in_ready", 32'(in_ready), 32'd1);
        expect_res(16'd8, 1'b0, CW'(8));
        for (int i = 0; i < 8; i++) send(16'h0001, 1'b0);
        tick();
        check("mrst_res_data", 32'(res_data), 32'd8);
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
